// File: rtl/axi_read_arbiter.sv
// ============================================================================
// axi_read_arbiter : shares one AXI read channel between I-cache and D-cache
// Revision 1.0
// ============================================================================
`default_nettype none

module axi_read_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  snoop_stall,

  input  logic                  i_arvalid,
  input  logic [ADDR_WIDTH-1:0] i_araddr,
  input  logic [7:0]            i_arlen,
  input  logic [2:0]            i_arsize,
  input  logic [1:0]            i_arburst,
  output logic                  i_arready,
  output logic                  i_rvalid,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_rlast,
  input  logic                  i_rready,

  input  logic                  d_arvalid,
  input  logic [ADDR_WIDTH-1:0] d_araddr,
  input  logic [7:0]            d_arlen,
  input  logic [2:0]            d_arsize,
  input  logic [1:0]            d_arburst,
  output logic                  d_arready,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_rlast,
  input  logic                  d_rready,

  output logic                  m_axi_arvalid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  input  logic                  m_axi_arready,
  input  logic                  m_axi_rvalid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic                  m_axi_rlast,
  output logic                  m_axi_rready,

  output logic                  icache_reading,
  output logic                  dcache_reading,
  output logic                  rlast_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t     state;
  logic       owner_d;
  logic       last_grant_d;
  logic [7:0] len_q;
  logic [7:0] beat_cnt;
  logic       err_seen;
  logic       rlast_err_q;

  logic                  own_arvalid;
  logic [ADDR_WIDTH-1:0] own_araddr;
  logic [7:0]            own_arlen;
  logic [2:0]            own_arsize;
  logic [1:0]            own_arburst;
  logic                  own_rready;
  logic                  want_d;
  logic                  beat;
  logic                  len_bad;
  logic                  active;
  logic                  in_addr;
  logic                  in_data;

  assign own_arvalid = owner_d ? d_arvalid : i_arvalid;
  assign own_araddr  = owner_d ? d_araddr  : i_araddr;
  assign own_arlen   = owner_d ? d_arlen   : i_arlen;
  assign own_arsize  = owner_d ? d_arsize  : i_arsize;
  assign own_arburst = owner_d ? d_arburst : i_arburst;
  assign own_rready  = owner_d ? d_rready  : i_rready;

  // On a tie the requester that did not win last time is granted.
  assign want_d  = d_arvalid & (~i_arvalid | ~last_grant_d);
  assign beat    = (state == DATA) & m_axi_rvalid & own_rready;
  assign len_bad = m_axi_rlast ? (beat_cnt != len_q) : (beat_cnt == len_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      owner_d      <= 1'b0;
      last_grant_d <= 1'b0;
      len_q        <= 8'd0;
      beat_cnt     <= 8'd0;
      err_seen     <= 1'b0;
      rlast_err_q  <= 1'b0;
    end else begin
      rlast_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!snoop_stall && (i_arvalid || d_arvalid)) begin
            owner_d <= want_d;
            state   <= ADDR;
          end
        end
        ADDR: begin
          if (!own_arvalid) begin
            state <= IDLE;
          end else if (m_axi_arready) begin
            len_q    <= own_arlen;
            beat_cnt <= 8'd0;
            err_seen <= 1'b0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (beat) begin
            if (beat_cnt != 8'hFF)
              beat_cnt <= beat_cnt + 8'd1;
            // Report only the first length violation of a burst.
            if (len_bad && !err_seen) begin
              rlast_err_q <= 1'b1;
              err_seen    <= 1'b1;
            end
            if (m_axi_rlast) begin
              state        <= IDLE;
              last_grant_d <= owner_d;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Everything is forced low while reset is held so nothing leaks mid-burst.
  assign active  = ~reset;
  assign in_addr = active & (state == ADDR);
  assign in_data = active & (state == DATA);

  always_comb begin
    m_axi_arvalid  = 1'b0;
    m_axi_araddr   = '0;
    m_axi_arlen    = 8'd0;
    m_axi_arsize   = 3'd0;
    m_axi_arburst  = 2'd0;
    m_axi_rready   = 1'b0;
    i_arready      = 1'b0;
    d_arready      = 1'b0;
    i_rvalid       = 1'b0;
    i_rdata        = '0;
    i_rlast        = 1'b0;
    d_rvalid       = 1'b0;
    d_rdata        = '0;
    d_rlast        = 1'b0;
    if (in_addr) begin
      m_axi_arvalid = own_arvalid;
      m_axi_araddr  = own_araddr;
      m_axi_arlen   = own_arlen;
      m_axi_arsize  = own_arsize;
      m_axi_arburst = own_arburst;
      i_arready     = ~owner_d & m_axi_arready;
      d_arready     =  owner_d & m_axi_arready;
    end
    if (in_data) begin
      m_axi_rready = own_rready;
      if (owner_d) begin
        d_rvalid = m_axi_rvalid;
        d_rdata  = m_axi_rdata;
        d_rlast  = m_axi_rlast;
      end else begin
        i_rvalid = m_axi_rvalid;
        i_rdata  = m_axi_rdata;
        i_rlast  = m_axi_rlast;
      end
    end
  end

  assign icache_reading = active & (state != IDLE) & ~owner_d;
  assign dcache_reading = active & (state != IDLE) &  owner_d;
  assign rlast_err      = active & rlast_err_q;

endmodule

`default_nettype wire

// File: tb/tb_axi_read_arbiter.sv
// ============================================================================
// tb_axi_read_arbiter : directed self-checking bench for axi_read_arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_axi_read_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        snoop_stall;
  logic        i_arvalid, d_arvalid;
  logic [63:0] i_araddr, d_araddr;
  logic [7:0]  i_arlen, d_arlen;
  logic [2:0]  i_arsize, d_arsize;
  logic [1:0]  i_arburst, d_arburst;
  logic        i_arready, d_arready;
  logic        i_rvalid, d_rvalid;
  logic [63:0] i_rdata, d_rdata;
  logic        i_rlast, d_rlast;
  logic        i_rready, d_rready;
  logic        m_axi_arvalid;
  logic [63:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arready;
  logic        m_axi_rvalid;
  logic [63:0] m_axi_rdata;
  logic        m_axi_rlast;
  logic        m_axi_rready;
  logic        icache_reading, dcache_reading, rlast_err;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int err_cnt  = 0;
  int err_base;

  always #5 clk = ~clk;

  axi_read_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
    .clk(clk), .reset(reset), .snoop_stall(snoop_stall),
    .i_arvalid(i_arvalid), .i_araddr(i_araddr), .i_arlen(i_arlen),
    .i_arsize(i_arsize), .i_arburst(i_arburst), .i_arready(i_arready),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rready(i_rready),
    .d_arvalid(d_arvalid), .d_araddr(d_araddr), .d_arlen(d_arlen),
    .d_arsize(d_arsize), .d_arburst(d_arburst), .d_arready(d_arready),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rready(d_rready),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arready(m_axi_arready),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rdata(m_axi_rdata),
    .m_axi_rlast(m_axi_rlast), .m_axi_rready(m_axi_rready),
    .icache_reading(icache_reading), .dcache_reading(dcache_reading),
    .rlast_err(rlast_err)
  );

  always @(negedge clk) if (rlast_err === 1'b1) err_cnt <= err_cnt + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Expects IDLE now with the winner's request applied; leaves the FSM in DATA.
  task automatic arb_to_data(input logic is_d, input logic [63:0] addr, input logic [7:0] len);
    @(negedge clk);
    check("idle_arvalid", m_axi_arvalid, 0);
    check("idle_flags", {icache_reading, dcache_reading}, 0);
    nxt();
    @(negedge clk);
    check("addr_arvalid", m_axi_arvalid, 1);
    check("addr_araddr", m_axi_araddr, addr);
    check("addr_arlen", m_axi_arlen, len);
    check("addr_flags", {icache_reading, dcache_reading}, is_d ? 2'b01 : 2'b10);
    check("addr_arready", {i_arready, d_arready}, is_d ? 2'b01 : 2'b10);
    nxt();
    if (is_d) d_arvalid = 0; else i_arvalid = 0;
  endtask

  // Drives n beats; rlast only on beat index last_at.
  task automatic burst(input logic is_d, input int n, input int last_at);
    logic [63:0] pat;
    for (int k = 0; k < n; k++) begin
      pat = 64'hC0DE_0000_0000_0000 | (64'(is_d) << 32) | 64'(k);
      m_axi_rvalid = 1;
      m_axi_rdata  = pat;
      m_axi_rlast  = (k == last_at);
      @(negedge clk);
      check("own_rvalid", is_d ? d_rvalid : i_rvalid, 1);
      check("own_rdata", is_d ? d_rdata : i_rdata, pat);
      check("own_rlast", is_d ? d_rlast : i_rlast, (k == last_at));
      check("oth_rvalid", is_d ? i_rvalid : d_rvalid, 0);
      check("oth_rdata", is_d ? i_rdata : d_rdata, 0);
      check("oth_arready", is_d ? i_arready : d_arready, 0);
      check("data_flags", {icache_reading, dcache_reading}, is_d ? 2'b01 : 2'b10);
      check("data_rready", m_axi_rready, 1);
      check("data_arvalid", m_axi_arvalid, 0);
      nxt();
    end
    m_axi_rvalid = 0;
    m_axi_rlast  = 0;
    m_axi_rdata  = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    nxt();
    nxt();
    @(negedge clk);
    check("rst_outs", {m_axi_arvalid, m_axi_rready, i_rvalid, d_rvalid,
                       icache_reading, dcache_reading, rlast_err}, 0);
    reset = 0;
    nxt();
  endtask

  initial begin
    reset = 1; snoop_stall = 0;
    i_arvalid = 0; i_araddr = 0; i_arlen = 0; i_arsize = 3'd3; i_arburst = 2'd1;
    d_arvalid = 0; d_araddr = 0; d_arlen = 0; d_arsize = 3'd3; d_arburst = 2'd1;
    i_rready = 1; d_rready = 1;
    m_axi_arready = 1; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rlast = 0;
    do_reset();

    // D only, arlen 7
    err_base = err_cnt;
    d_arvalid = 1; d_araddr = 64'h8000_0040; d_arlen = 8'd7;
    arb_to_data(1, 64'h8000_0040, 8'd7);
    check("t1_arsize", {i_arsize, d_arsize}, 6'o33);
    burst(1, 8, 7);
    @(negedge clk);
    check("t1_idle_flags", {icache_reading, dcache_reading}, 0);
    check("t1_err", err_cnt - err_base, 0);

    // tie from reset: D first, then I, then tie again goes to D
    do_reset();
    i_arvalid = 1; i_araddr = 64'h1000; i_arlen = 8'd1;
    d_arvalid = 1; d_araddr = 64'h2000; d_arlen = 8'd3;
    arb_to_data(1, 64'h2000, 8'd3);
    burst(1, 4, 3);
    arb_to_data(0, 64'h1000, 8'd1);
    burst(0, 2, 1);
    i_arvalid = 1; d_arvalid = 1; d_arlen = 8'd0;
    arb_to_data(1, 64'h2000, 8'd0);
    burst(1, 1, 0);
    // I still waiting; during its burst D requests and must wait
    arb_to_data(0, 64'h1000, 8'd1);
    d_arvalid = 1; d_araddr = 64'h3000; d_arlen = 8'd1;
    burst(0, 2, 1);
    arb_to_data(1, 64'h3000, 8'd1);
    burst(1, 2, 1);

    // snoop stall holds off the grant, never a running burst
    snoop_stall = 1; i_arvalid = 1; i_araddr = 64'h4000; i_arlen = 8'd3;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_arvalid", m_axi_arvalid, 0);
      check("stall_arready", i_arready, 0);
      nxt();
    end
    snoop_stall = 0;
    arb_to_data(0, 64'h4000, 8'd3);
    burst(0, 1, 99);
    snoop_stall = 1;
    burst(0, 3, 2);
    snoop_stall = 0;

    // early rlast on beat 2 of 4
    err_base = err_cnt;
    d_arvalid = 1; d_araddr = 64'h5000; d_arlen = 8'd3;
    arb_to_data(1, 64'h5000, 8'd3);
    burst(1, 2, 1);
    @(negedge clk);
    check("t5a_idle", {icache_reading, dcache_reading}, 0);
    nxt();
    check("t5a_err", err_cnt - err_base, 1);

    // missing rlast on beat 4 of 4; burst ends on beat 5
    err_base = err_cnt;
    d_arvalid = 1;
    arb_to_data(1, 64'h5000, 8'd3);
    burst(1, 5, 4);
    @(negedge clk);
    check("t5b_idle", {icache_reading, dcache_reading}, 0);
    nxt();
    check("t5b_err", err_cnt - err_base, 1);

    // reset in the middle of a burst
    d_arvalid = 1; d_araddr = 64'h6000; d_arlen = 8'd7;
    arb_to_data(1, 64'h6000, 8'd7);
    burst(1, 2, 99);
    m_axi_rvalid = 1; m_axi_rdata = 64'hDEAD;
    reset = 1;
    @(negedge clk);
    check("midrst_during", {d_rvalid, m_axi_rready, dcache_reading}, 0);
    nxt();
    reset = 0;
    @(negedge clk);
    check("midrst_after", {m_axi_arvalid, m_axi_rready, i_rvalid, d_rvalid,
                           icache_reading, dcache_reading, rlast_err}, 0);
    check("midrst_rdata", d_rdata, 0);
    nxt();
    m_axi_rvalid = 0; m_axi_rdata = 0;
    err_base = err_cnt;
    d_arvalid = 1; d_araddr = 64'h7000; d_arlen = 8'd7;
    arb_to_data(1, 64'h7000, 8'd7);
    burst(1, 8, 7);
    nxt();
    check("t6_err", err_cnt - err_base, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Shares the single AXI read address and read data channels between the instruction cache (requester I) and the data cache (requester D).
- Grants one requester at a time and locks that grant for the whole burst, from the AR handshake through the R beat with rlast.
- Drives the icache_reading / dcache_reading ownership flags that both caches use to defer to each other.
- Sits between the two cache controllers and the core's AXI master port. It also holds off new grants while a snoop stall is active.

Parameters:
ADDR_WIDTH, 64, width of araddr on all ports
DATA_WIDTH, 64, width of rdata on all ports

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
snoop_stall  in  1  while high, no new grant is issued (a burst already in progress continues)
i_arvalid  in  1  I-cache read address valid
i_araddr  in  ADDR_WIDTH  I-cache read address
i_arlen  in  8  I-cache burst length minus 1
i_arsize  in  3  I-cache beat size
i_arburst  in  2  I-cache burst type
i_arready  out  1  AR handshake ready returned to I-cache
i_rvalid  out  1  R beat valid routed to I-cache
i_rdata  out  DATA_WIDTH  R data routed to I-cache
i_rlast  out  1  last beat flag routed to I-cache
i_rready  in  1  I-cache ready to accept R beat
d_arvalid, d_araddr, d_arlen, d_arsize, d_arburst  in  1/ADDR_WIDTH/8/3/2  D-cache AR request
d_arready  out  1  AR handshake ready returned to D-cache
d_rvalid, d_rdata, d_rlast  out  1/DATA_WIDTH/1  R beat routed to D-cache
d_rready  in  1  D-cache ready to accept R beat
m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst  out  1/ADDR_WIDTH/8/3/2  AR channel to interconnect
m_axi_arready  in  1  AR ready from interconnect
m_axi_rvalid, m_axi_rdata, m_axi_rlast  in  1/DATA_WIDTH/1  R channel from interconnect
m_axi_rready  out  1  R ready to interconnect
icache_reading  out  1  I owns the read channel
dcache_reading  out  1  D owns the read channel
rlast_err  out  1  one-cycle pulse on a burst length mismatch

Behaviour:
- Reset: synchronous, active-high. The FSM goes to IDLE, the owner register clears, the beat counter clears, and last_grant is set to I so that D wins the first tie. All outputs read 0 during reset and in the cycle after reset.
- State IDLE: all m_axi_* outputs, all requester-side outputs, and both *_reading flags are 0.
  - If snoop_stall is 0 and any arvalid is high, the arbiter registers a grant and moves to ADDR.
  - Only one requester valid: that requester is granted.
  - Both valid: round-robin, granting the requester that is not last_grant.
  - Latency: a request visible at edge N gives m_axi_arvalid = 1 in the cycle after edge N.
- State ADDR: m_axi_ar* is a combinational pass-through of the owner's ar* fields. The owner's arready equals m_axi_arready; the non-owner's arready is 0.
  - On m_axi_arvalid & m_axi_arready: latch the owner's arlen into len_q, clear beat_cnt, move to DATA.
  - If the owner drops arvalid before the handshake (an AXI violation): abandon, return to IDLE, and leave last_grant unchanged.
- State DATA: the owner's r* outputs equal m_axi_r*, and m_axi_rready equals the owner's rready. The non-owner's rvalid is 0; its rdata and rlast are 0.
  - m_axi_arvalid is 0 in DATA.
  - beat_cnt increments on every rvalid & rready beat.
  - A beat with rlast: move to IDLE and set last_grant to the owner.
  - Next grant: earliest is in the cycle after the rlast beat, so there is one dead cycle between bursts.
- rlast_err: pulses for 1 cycle in either of these cases:
  - rlast is accepted while beat_cnt != len_q;
  - beat_cnt == len_q and a beat is accepted without rlast (the FSM stays in DATA until rlast arrives).
- icache_reading = (state != IDLE) & owner == I. dcache_reading = (state != IDLE) & owner == D. Both flags are valid from the cycle m_axi_arvalid first rises through the rlast beat cycle inclusive.
- snoop_stall only gates the IDLE→ADDR transition. It never interrupts ADDR or DATA.
- Simultaneous events: a new request arriving during ADDR or DATA waits, and its arready stays 0. A request whose arvalid is high in the rlast cycle is arbitrated in the next IDLE cycle.
- Reset mid-burst: the FSM returns to IDLE immediately and the remaining R beats are not routed. This is acceptable only because reset is system-wide.
- Beat counter: 8 bits, never wraps, since arlen ≤ 255.

Test Plan:
1. D only: d_arvalid=1, araddr=0x8000_0040, arlen=7. Interconnect asserts arready in the same cycle → m_axi_arvalid high one cycle after the request, 8 beats reach the D-cache, dcache_reading=1 throughout, returns to IDLE after rlast, rlast_err=0.
2. Simultaneous I and D from reset → D granted first. I is granted in the cycle after D's rlast. Then a second tie → D granted (round-robin alternates).
3. I burst in DATA, D asserts arvalid → d_arready stays 0 and d_rvalid stays 0 for every I beat. D is granted only after I's rlast.
4. snoop_stall=1 with i_arvalid=1 for 5 cycles → m_axi_arvalid stays 0. Stall drops → m_axi_arvalid=1 next cycle. Stall raised mid-burst → beats continue uninterrupted.
5. arlen=3 with rlast on beat 2, and separately no rlast on beat 4 → rlast_err pulses exactly once in each case. The FSM returns to IDLE only on an rlast beat.
6. Reset asserted in DATA after 2 of 8 beats → all outputs are 0 in the cycle after reset. A new d_arvalid is then granted normally.
